// File: rtl/axi4lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master control port.
// Optional error log enabled by defining ARB_ERR_LOG_EN.
module axi4lite_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*4-1:0]            req_wstrb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            m_start,
    output logic                            m_write,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]           m_wdata,
    output logic [3:0]                      m_wstrb,
    input  logic                            m_busy,
    input  logic                            m_done,
    input  logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic [1:0]                      m_resp,
    output logic [ID_W-1:0]                 grant_id,
`ifdef ARB_ERR_LOG_EN
    output logic                            err_valid,
    output logic [ID_W-1:0]                 err_id,
    output logic [ADDR_WIDTH-1:0]           err_addr,
    input  logic                            err_clr,
`endif
    output logic                            active
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         grant_q;
    logic [ID_W-1:0]         sel;
    logic [ID_W-1:0]         cand;
    logic                    any_req;
    logic                    grant_fire;
    logic                    done_fire;
    logic                    rsp_fire;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    // First pending requester at or after rr_ptr, wrapping.
    always_comb begin
        sel     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        m_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && ARESETn) begin
                    req_ready[sel] = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_busy) begin
                    m_start = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (m_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_fire = (state_q == IDLE) && any_req;
    assign done_fire  = (state_q == WAIT) && m_done;
    assign rsp_fire   = (state_q == RESP) && rsp_ready[grant_q];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                grant_q <= sel;
                write_q <= req_write[sel];
                addr_q  <= req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                wstrb_q <= req_wstrb[int'(sel)*4 +: 4];
            end
            if (done_fire) begin
                rdata_q <= write_q ? '0 : m_rdata;
                resp_q  <= m_resp;
            end
            if (rsp_fire) begin
                if (int'(grant_q) == NUM_REQ - 1) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= grant_q + 1'b1;
                end
            end
        end
    end

`ifdef ARB_ERR_LOG_EN
    // Sticky first-error capture; a fresh error beats a coincident clear.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_valid <= 1'b0;
            err_id    <= '0;
            err_addr  <= '0;
        end else if (done_fire && (m_resp != 2'b00)
                     && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_id    <= grant_q;
            err_addr  <= addr_q;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
`endif

    assign m_write   = write_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign grant_id  = grant_q;
    assign active    = (state_q != IDLE);

endmodule
